// File: rtl/rsa_modexp_core.sv
// Modular exponentiation engine: LSB-first square-and-multiply.
// Each modular product is a bit-serial Blakley interleaved multiply.
module rsa_modexp_core #(
    parameter int W = 32
) (
    input  logic         PCLK,
    input  logic         PRESETN,
    input  logic         start,
    input  logic [W-1:0] base,
    input  logic [W-1:0] exponent,
    input  logic [W-1:0] modulus,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [W-1:0]  ONE_W   = W'(1);

    typedef enum logic [2:0] {
        IDLE, REDUCE, CHECK, MUL, SQR, DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  e_q, e_d;
    logic [W-1:0]  n_q, n_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  result_q, result_d;
    logic          err_q, err_d;

    logic [W-1:0] x_op, y_op, step_val;
    logic [W:0]   n_ext, a_dbl, a_red, a_add, a_fin;
    logic         last, mod_bad;

    assign last    = (cnt_q == '0);
    assign mod_bad = (modulus[W-1:1] == '0);

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state_q  <= IDLE;
            b_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            e_q      <= e_d;
            n_q      <= n_d;
            r_q      <= r_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = mod_bad ? DONE : REDUCE;
                end
            end
            REDUCE: if (last) state_d = CHECK;
            CHECK: begin
                if (e_q == '0) begin
                    state_d = DONE;
                end else if (e_q[0]) begin
                    state_d = MUL;
                end else begin
                    state_d = SQR;
                end
            end
            MUL:  if (last) state_d = SQR;
            SQR:  if (last) state_d = CHECK;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One Blakley step: both partial sums stay below 2n, so one subtract each
    always_comb begin
        x_op = b_q;
        y_op = ONE_W;
        if (state_q == MUL) begin
            x_op = r_q;
            y_op = b_q;
        end else if (state_q == SQR) begin
            y_op = b_q;
        end
        n_ext    = {1'b0, n_q};
        a_dbl    = {acc_q, 1'b0};
        a_red    = (a_dbl >= n_ext) ? (a_dbl - n_ext) : a_dbl;
        a_add    = x_op[cnt_q] ? (a_red + {1'b0, y_op}) : a_red;
        a_fin    = (a_add >= n_ext) ? (a_add - n_ext) : a_add;
        step_val = a_fin[W-1:0];
    end

    always_comb begin
        b_d      = b_q;
        e_d      = e_q;
        n_d      = n_q;
        r_d      = r_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    b_d   = base;
                    e_d   = exponent;
                    n_d   = modulus;
                    err_d = 1'b0;
                    if (mod_bad) begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        acc_d = '0;
                        r_d   = ONE_W;
                        cnt_d = CNT_MAX;
                    end
                end
            end
            REDUCE, MUL, SQR: begin
                acc_d = step_val;
                cnt_d = cnt_q - CNT_ONE;
                if (last) begin
                    acc_d = '0;
                    cnt_d = CNT_MAX;
                    if (state_q == MUL) begin
                        r_d = step_val;
                    end else begin
                        b_d = step_val;
                    end
                    if (state_q == SQR) begin
                        e_d = e_q >> 1;
                    end
                end
            end
            CHECK: begin
                if (e_q == '0) begin
                    result_d = r_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        err    = err_q;
        result = result_q;
    end

endmodule
